// File: rtl/i2c_write_sched_if.sv
// Client-request and I2C pad signals of the two-requester write scheduler.
// The master side is the client/bus environment; the slave side is the scheduler.
`timescale 1ns/1ps
interface i2c_write_sched_if;
  logic [1:0] req;
  logic [6:0] addr0;
  logic [6:0] addr1;
  logic [7:0] data0;
  logic [7:0] data1;
  logic       sda_in;
  logic       scl;
  logic       sda_oe;
  logic [1:0] grant;
  logic       busy;
  logic       done;
  logic       nack;

  modport master (
    output req, addr0, addr1, data0, data1, sda_in,
    input  scl, sda_oe, grant, busy, done, nack
  );

  modport slave (
    input  req, addr0, addr1, data0, data1, sda_in,
    output scl, sda_oe, grant, busy, done, nack
  );
endinterface

// File: rtl/i2c_write_sched.sv
// Round-robin two-client I2C single-byte write master: START, addr+W, ACK, data, ACK, STOP.
// scl/sda_oe are registered from next-state decode so pad timing is glitch-free and quarter-aligned.
`timescale 1ns/1ps
module i2c_write_sched #(
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               reset,
  i2c_write_sched_if.slave   sif
);

  typedef enum logic [2:0] {IDLE, START, ADDR, ACK_A, DATA, ACK_D, STOP, FIN} state_t;

  state_t     state_reg, state_next;
  logic [7:0] qcnt_reg, qcnt_next;
  logic [1:0] q_reg, q_next;
  logic [2:0] bit_reg, bit_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] data_reg, data_next;
  logic [1:0] grant_reg, grant_next;
  logic       busy_reg, busy_next;
  logic       rr_reg, rr_next;
  logic       flag_reg, flag_next;
  logic       done_reg, done_next;
  logic       nack_reg, nack_next;
  logic       scl_reg, scl_next;
  logic       sda_oe_reg, sda_oe_next;

  logic tick;
  logic slot_end;
  logic win1;

  assign tick     = (qcnt_reg == 8'(CLK_DIV - 1));
  assign slot_end = tick && (q_reg == 2'd3);
  // rr_reg names the client that wins a tie.
  assign win1     = sif.req[1] & (~sif.req[0] | rr_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      qcnt_reg   <= '0;
      q_reg      <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      data_reg   <= '0;
      grant_reg  <= '0;
      busy_reg   <= 1'b0;
      rr_reg     <= 1'b0;
      flag_reg   <= 1'b0;
      done_reg   <= 1'b0;
      nack_reg   <= 1'b0;
      scl_reg    <= 1'b1;
      sda_oe_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      qcnt_reg   <= qcnt_next;
      q_reg      <= q_next;
      bit_reg    <= bit_next;
      shift_reg  <= shift_next;
      data_reg   <= data_next;
      grant_reg  <= grant_next;
      busy_reg   <= busy_next;
      rr_reg     <= rr_next;
      flag_reg   <= flag_next;
      done_reg   <= done_next;
      nack_reg   <= nack_next;
      scl_reg    <= scl_next;
      sda_oe_reg <= sda_oe_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    qcnt_next  = qcnt_reg;
    q_next     = q_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    data_next  = data_reg;
    grant_next = grant_reg;
    busy_next  = busy_reg;
    rr_next    = rr_reg;
    flag_next  = flag_reg;
    done_next  = 1'b0;
    nack_next  = 1'b0;

    if (state_reg != IDLE && state_reg != FIN) begin
      qcnt_next = tick ? 8'd0 : qcnt_reg + 8'd1;
      if (tick) q_next = q_reg + 2'd1;
    end

    case (state_reg)
      IDLE: begin
        if (sif.req != 2'b00) begin
          grant_next = win1 ? 2'b10 : 2'b01;
          shift_next = win1 ? {sif.addr1, 1'b0} : {sif.addr0, 1'b0};
          data_next  = win1 ? sif.data1 : sif.data0;
          busy_next  = 1'b1;
          flag_next  = 1'b0;
          qcnt_next  = '0;
          q_next     = '0;
          bit_next   = '0;
          state_next = START;
        end
      end
      START: begin
        if (slot_end) state_next = ADDR;
      end
      ADDR, DATA: begin
        if (slot_end) begin
          shift_next = {shift_reg[6:0], 1'b0};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) state_next = (state_reg == ADDR) ? ACK_A : ACK_D;
        end
      end
      ACK_A, ACK_D: begin
        // Sample on the last clk of q2, while SCL is high.
        if (tick && q_reg == 2'd2 && sif.sda_in) flag_next = 1'b1;
        if (slot_end) begin
          if (state_reg == ACK_A && !flag_reg) begin
            shift_next = data_reg;
            state_next = DATA;
          end else begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (slot_end) state_next = FIN;
      end
      FIN: begin
        done_next  = 1'b1;
        nack_next  = flag_reg;
        grant_next = '0;
        busy_next  = 1'b0;
        rr_next    = grant_reg[0];
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    scl_next    = 1'b1;
    sda_oe_next = 1'b0;
    case (state_next)
      START: sda_oe_next = q_next[1];
      ADDR, DATA: begin
        scl_next    = q_next[1];
        sda_oe_next = ~shift_next[7];
      end
      ACK_A, ACK_D: scl_next = q_next[1];
      STOP: begin
        scl_next    = (q_next != 2'd0);
        sda_oe_next = (q_next != 2'd3);
      end
      default: begin
        scl_next    = 1'b1;
        sda_oe_next = 1'b0;
      end
    endcase
  end

  assign sif.scl    = scl_reg;
  assign sif.sda_oe = sda_oe_reg;
  assign sif.grant  = grant_reg;
  assign sif.busy   = busy_reg;
  assign sif.done   = done_reg;
  assign sif.nack   = nack_reg;

endmodule

// File: tb/tb_i2c_write_sched.sv
// Directed bench for i2c_write_sched: one CLK_DIV=4 instance and one CLK_DIV=1 instance.
// Bus monitors decode START/STOP and clocked bits from the master's own SDA drive.
`timescale 1ns/1ps
module tb_i2c_write_sched;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2c_write_sched_if if0 ();
  i2c_write_sched_if if1 ();

  i2c_write_sched #(.CLK_DIV(4)) u_dut  (.clk(clk), .reset(reset), .sif(if0));
  i2c_write_sched #(.CLK_DIV(1)) u_dut1 (.clk(clk), .reset(reset), .sif(if1));

  // A bit is committed when SCL falls after a high phase; a STOP during the high phase discards it.
  logic        m0_pscl = 1'b1, m0_psda = 1'b1, m0_pend = 1'b0, m0_pbit = 1'b0;
  int          m0_starts = 0, m0_stops = 0, m0_n = 0;
  logic [63:0] m0_bits = '0;
  logic        m0_sda;
  assign m0_sda = ~if0.sda_oe;
  always @(negedge clk) begin
    if (m0_pscl && if0.scl && m0_psda && !m0_sda) m0_starts <= m0_starts + 1;
    if (m0_pscl && if0.scl && !m0_psda && m0_sda) begin
      m0_stops <= m0_stops + 1;
      m0_pend  <= 1'b0;
    end else if (!m0_pscl && if0.scl) begin
      m0_pend <= 1'b1;
      m0_pbit <= m0_sda;
    end else if (m0_pscl && !if0.scl && m0_pend) begin
      m0_bits <= {m0_bits[62:0], m0_pbit};
      m0_n    <= m0_n + 1;
      m0_pend <= 1'b0;
    end
    m0_pscl <= if0.scl;
    m0_psda <= m0_sda;
  end

  logic        m1_pscl = 1'b1, m1_psda = 1'b1, m1_pend = 1'b0, m1_pbit = 1'b0;
  int          m1_starts = 0, m1_stops = 0, m1_n = 0;
  logic [63:0] m1_bits = '0;
  logic        m1_sda;
  assign m1_sda = ~if1.sda_oe;
  always @(negedge clk) begin
    if (m1_pscl && if1.scl && m1_psda && !m1_sda) m1_starts <= m1_starts + 1;
    if (m1_pscl && if1.scl && !m1_psda && m1_sda) begin
      m1_stops <= m1_stops + 1;
      m1_pend  <= 1'b0;
    end else if (!m1_pscl && if1.scl) begin
      m1_pend <= 1'b1;
      m1_pbit <= m1_sda;
    end else if (m1_pscl && !if1.scl && m1_pend) begin
      m1_bits <= {m1_bits[62:0], m1_pbit};
      m1_n    <= m1_n + 1;
      m1_pend <= 1'b0;
    end
    m1_pscl <= if1.scl;
    m1_psda <= m1_sda;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int inst, input int which);
    if (inst == 0) return (which == 0) ? (if0.grant != 2'b00) : if0.done;
    return (which == 0) ? (if1.grant != 2'b00) : if1.done;
  endfunction

  // Waits (bounded) for grant (which=0) or done (which=1); returns the cycle stamp.
  task automatic wait_for(input string tag, input int inst, input int which, output int t);
    logic found;
    found = 1'b0;
    t = -1;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (sig(inst, which)) begin
        found = 1'b1;
        t = cyc;
      end
    end
    chk({tag, "_seen"}, 64'(found), 64'd1);
  endtask

  int t_g, t_d, t_prev, s0, p0, n0, s1, p1, n1;
  logic [1:0] exp_g;

  initial begin
    if0.req = 2'b00; if0.addr0 = 7'h50; if0.data0 = 8'hA5;
    if0.addr1 = 7'h3C; if0.data1 = 8'hE5; if0.sda_in = 1'b0;
    if1.req = 2'b00; if1.addr0 = 7'h00; if1.data0 = 8'h00;
    if1.addr1 = 7'h7F; if1.data1 = 8'hFF; if1.sda_in = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_scl", 64'(if0.scl), 64'd1);
    chk("rst_sda_oe", 64'(if0.sda_oe), 64'd0);
    chk("rst_grant_busy", 64'({if0.grant, if0.busy}), 64'd0);
    chk("rst_done_nack", 64'({if0.done, if0.nack}), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Client 0 full ACKed write
    s0 = m0_starts; p0 = m0_stops; n0 = m0_n;
    if0.req = 2'b01;
    wait_for("t1_grant", 0, 0, t_g);
    chk("t1_grant", 64'(if0.grant), 64'b01);
    chk("t1_busy", 64'(if0.busy), 64'd1);
    wait_for("t1_done", 0, 1, t_d);
    if0.req = 2'b00;
    $display("T1 client0 write: grant@%0d done@%0d nack=%0b", t_g, t_d, if0.nack);
    chk("t1_latency", 64'(t_d - t_g), 64'd321);
    chk("t1_nack", 64'(if0.nack), 64'd0);
    chk("t1_release", 64'({if0.grant, if0.busy}), 64'd0);
    chk("t1_nbits", 64'(m0_n - n0), 64'd18);
    chk("t1_bits", 64'(m0_bits[17:0]), 64'({8'hA0, 1'b1, 8'hA5, 1'b1}));
    chk("t1_start_stop", 64'({m0_starts - s0, m0_stops - p0}), {32'd1, 32'd1});
    @(negedge clk);
    chk("t1_done_pulse", 64'({if0.done, if0.nack}), 64'd0);

    // Address NACK from client 1
    s0 = m0_starts; p0 = m0_stops; n0 = m0_n;
    if0.sda_in = 1'b1;
    if0.req = 2'b10;
    wait_for("t2_grant", 0, 0, t_g);
    chk("t2_grant", 64'(if0.grant), 64'b10);
    wait_for("t2_done", 0, 1, t_d);
    if0.req = 2'b00;
    $display("T2 addr nack: grant@%0d done@%0d nack=%0b", t_g, t_d, if0.nack);
    chk("t2_latency", 64'(t_d - t_g), 64'd177);
    chk("t2_nack", 64'(if0.nack), 64'd1);
    chk("t2_nbits", 64'(m0_n - n0), 64'd9);
    chk("t2_bits", 64'(m0_bits[8:0]), 64'({8'h78, 1'b1}));
    chk("t2_start_stop", 64'({m0_starts - s0, m0_stops - p0}), {32'd1, 32'd1});
    @(negedge clk);
    chk("t2_nack_clear", 64'({if0.done, if0.nack}), 64'd0);
    if0.sda_in = 1'b0;

    // Round-robin with both requests held
    if0.req = 2'b11;
    t_d = 0;
    for (int i = 0; i < 4; i++) begin
      t_prev = t_d;
      wait_for("rr_grant", 0, 0, t_g);
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      chk("rr_grant", 64'(if0.grant), 64'(exp_g));
      if (i > 0) chk("rr_idle_gap", 64'(t_g - t_prev), 64'd1);
      wait_for("rr_done", 0, 1, t_d);
      if (i == 3) if0.req = 2'b00;
      $display("T3 rr #%0d: grant=%b @%0d done@%0d nack=%0b", i, exp_g, t_g, t_d, if0.nack);
      chk("rr_nack", 64'(if0.nack), 64'd0);
    end
    @(negedge clk);

    // Client 0 drops req and changes inputs during ADDR
    n0 = m0_n;
    if0.addr0 = 7'h2A; if0.data0 = 8'h5C;
    if0.req = 2'b01;
    wait_for("t4_grant", 0, 0, t_g);
    repeat (20) @(negedge clk);
    if0.req = 2'b00; if0.addr0 = 7'h11; if0.data0 = 8'h00;
    wait_for("t4_done", 0, 1, t_d);
    $display("T4 req drop: grant@%0d done@%0d nack=%0b", t_g, t_d, if0.nack);
    chk("t4_latency", 64'(t_d - t_g), 64'd321);
    chk("t4_bits", 64'(m0_bits[17:0]), 64'({8'h54, 1'b1, 8'h5C, 1'b1}));
    chk("t4_nbits", 64'(m0_n - n0), 64'd18);
    @(negedge clk);

    // Tie after client 0 went last -> client 1; reset during DATA bit 3 (q1)
    if0.req = 2'b11;
    wait_for("t5_grant", 0, 0, t_g);
    chk("t5_grant", 64'(if0.grant), 64'b10);
    repeat (212) @(negedge clk);
    chk("t5_pre_scl_oe", 64'({if0.scl, if0.sda_oe, if0.busy}), 64'b011);
    reset = 1'b0;
    #1;
    chk("t5_rst_scl_oe", 64'({if0.scl, if0.sda_oe}), 64'b10);
    chk("t5_rst_grant_busy", 64'({if0.grant, if0.busy}), 64'd0);
    $display("T5 reset mid-DATA: scl=%0b sda_oe=%0b grant=%b busy=%0b", if0.scl, if0.sda_oe, if0.grant, if0.busy);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_for("t5_regrant", 0, 0, t_g);
    chk("t5_regrant", 64'(if0.grant), 64'b01);
    wait_for("t5_done", 0, 1, t_d);
    if0.req = 2'b00;
    chk("t5_latency", 64'(t_d - t_g), 64'd321);
    @(negedge clk);

    // CLK_DIV=1 instance, client 1 writes 0x7F/0xFF
    s1 = m1_starts; p1 = m1_stops; n1 = m1_n;
    if1.req = 2'b10;
    wait_for("t6_grant", 1, 0, t_g);
    chk("t6_grant", 64'(if1.grant), 64'b10);
    wait_for("t6_done", 1, 1, t_d);
    if1.req = 2'b00;
    $display("T6 div1 write: grant@%0d done@%0d nack=%0b", t_g, t_d, if1.nack);
    chk("t6_latency", 64'(t_d - t_g), 64'd81);
    chk("t6_nack", 64'(if1.nack), 64'd0);
    chk("t6_nbits", 64'(m1_n - n1), 64'd18);
    chk("t6_bits", 64'(m1_bits[17:0]), 64'({8'hFE, 1'b1, 8'hFF, 1'b1}));
    chk("t6_start_stop", 64'({m1_starts - s1, m1_stops - p1}), {32'd1, 32'd1});
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
